// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU stage: op codes and FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package alu_pkg;

    // Operation select carried on cmd_op.
    typedef logic [2:0] op_t;

    localparam op_t OP_ZERO  = 3'd0;  // F = 0
    localparam op_t OP_BSUBA = 3'd1;  // F = B - A
    localparam op_t OP_ASUBB = 3'd2;  // F = A - B
    localparam op_t OP_ADD   = 3'd3;  // F = A + B
    localparam op_t OP_XOR   = 3'd4;  // F = A ^ B
    localparam op_t OP_OR    = 3'd5;  // F = A | B
    localparam op_t OP_AND   = 3'd6;  // F = A & B
    localparam op_t OP_ONES  = 3'd7;  // F = all ones

    // Stage sequencer states, kept as plain constants so older blocks can share them.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;  // waiting for a command
    localparam state_t ST_EXEC = 2'd1;  // computing F, updating ACC
    localparam state_t ST_HOLD = 2'd2;  // result presented until consumed

endpackage

// File: rtl/accum_alu_stage_if.sv
// Command/result handshake bundle between a producer/consumer and the ALU stage.
// Latency: none (wiring only).
// Backpressure: cmd side valid/ready, result side valid/ready.
interface accum_alu_stage_if #(
    parameter int DATA_W = 4
);
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    op_t               cmd_op;
    logic [DATA_W-1:0] cmd_data;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic              res_carry;
    logic              res_zero;

    // Side that issues commands and consumes results.
    modport master (
        output cmd_valid, cmd_op, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_carry, res_zero
    );

    // The ALU stage itself.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_carry, res_zero
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: F(op, A, B) plus carry/borrow flag, modulo 2^DATA_W.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated continuously from its inputs.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  op_t               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] f_o,
    output logic              carry_o
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a_i} + {1'b0, b_i};

    // Select result and flag; subtract borrow is the unsigned compare of the operands.
    always_comb begin
        f_o     = '0;
        carry_o = 1'b0;
        case (op_i)
            OP_ZERO: f_o = '0;
            OP_BSUBA: begin
                f_o     = b_i - a_i;
                carry_o = (b_i < a_i);
            end
            OP_ASUBB: begin
                f_o     = a_i - b_i;
                carry_o = (a_i < b_i);
            end
            OP_ADD: begin
                f_o     = sum[DATA_W-1:0];
                carry_o = sum[DATA_W];
            end
            OP_XOR:  f_o = a_i ^ b_i;
            OP_OR:   f_o = a_i | b_i;
            OP_AND:  f_o = a_i & b_i;
            OP_ONES: f_o = '1;
            default: f_o = '0;
        endcase
    end

endmodule

// File: rtl/accum_alu_stage.sv
// Accumulator ALU stage: ACC <= F(op, ACC, B) per accepted command; ACC is also the result. Optional carry counter under ACCUM_OVF_CNT_EN.
// Latency: result valid after the second clock edge counting the accepting edge (accept -> EXEC -> HOLD).
// Backpressure: result held in HOLD until res_ready; a new command is accepted in the same cycle the result is taken.
module accum_alu_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic               clk,
    input  logic               clr,
    accum_alu_stage_if.slave   bus,
    output logic [7:0]         ovf_cnt
);

    state_t            state_q, state_d;
    op_t               op_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] acc_q;
    logic              carry_q;
    logic              zero_q;

    logic              cmd_fire;
    logic [DATA_W-1:0] alu_f;
    logic              alu_carry;

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .op_i    (op_q),
        .a_i     (acc_q),
        .b_i     (b_q),
        .f_o     (alu_f),
        .carry_o (alu_carry)
    );

    // A slot opens when idle, or when the held result leaves this cycle.
    assign bus.cmd_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.res_ready);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

    // The accumulator is the result register; flags travel with it.
    assign bus.res_valid = (state_q == ST_HOLD);
    assign bus.res_data  = acc_q;
    assign bus.res_carry = carry_q;
    assign bus.res_zero  = zero_q;

    // Next-state sequencing: accept -> execute -> hold until consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_fire) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_HOLD;
            ST_HOLD: begin
                if (bus.res_ready) state_d = bus.cmd_valid ? ST_EXEC : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight command or held result.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Capture the operands only on an accepted command.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            op_q <= OP_ZERO;
            b_q  <= '0;
        end else if (cmd_fire) begin
            op_q <= bus.cmd_op;
            b_q  <= bus.cmd_data;
        end
    end

    // ACC and flags update only while executing, so the held result stays stable.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            acc_q   <= alu_f;
            carry_q <= alu_carry;
            zero_q  <= (alu_f == '0);
        end
    end

`ifdef ACCUM_OVF_CNT_EN
    logic [7:0] ovf_q;

    // Count executions that produced a carry/borrow, sticking at the top value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) ovf_q <= 8'd0;
        else if ((state_q == ST_EXEC) && alu_carry && (ovf_q != 8'hFF))
            ovf_q <= ovf_q + 8'd1;
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_accum_alu_stage.sv
// Directed bench for accum_alu_stage with hand-computed expectations (DATA_W = 4).
// Latency: checks result valid after the second edge counting the accepting edge.
// Backpressure: exercises a 5-cycle result stall and same-cycle consume/accept.
module tb_accum_alu_stage;

    logic       clk;
    logic       clr;
    logic [7:0] ovf_cnt;

    int n_chk = 0;
    int n_bad = 0;

    accum_alu_stage_if #(.DATA_W(4)) bus ();

    accum_alu_stage #(
        .DATA_W (4)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus),
        .ovf_cnt (ovf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Offer one command from IDLE; returns one tick after the result should appear.
    task automatic issue(input logic [2:0] op, input logic [3:0] b);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = b;
        #1;
        chk("issue_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_data  = 4'($urandom);
        chk("res_valid_edge1", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        chk("res_valid_edge2", 32'(bus.res_valid), 32'd1);
    endtask

    // Check the held result.
    task automatic res_is(input string tag, input logic [3:0] d, input logic c, input logic z);
        chk({tag, "_data"},  32'(bus.res_data),  32'(d));
        chk({tag, "_carry"}, 32'(bus.res_carry), 32'(c));
        chk({tag, "_zero"},  32'(bus.res_zero),  32'(z));
    endtask

    // With res_ready high, the next edge takes the result and returns to IDLE.
    task automatic consume(input string tag);
        @(posedge clk); #1;
        chk({tag, "_dropped"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        clr           = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 4'd0;
        bus.res_ready = 1'b0;

        // Reset state
        #2;
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data",  32'(bus.res_data),  32'd0);
        chk("rst_res_carry", 32'(bus.res_carry), 32'd0);
        chk("rst_res_zero",  32'(bus.res_zero),  32'd0);
        chk("rst_ovf_cnt",   32'(ovf_cnt),       32'd0);
        repeat (2) @(posedge clk);
        #3 clr = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("post_rst_res_valid", 32'(bus.res_valid), 32'd0);

        // 0 + 5 = 5
        bus.res_ready = 1'b1;
        issue(3'd3, 4'd5);
        res_is("add5", 4'd5, 1'b0, 1'b0);
        consume("add5");

        // ACC = 15 via all-ones, then 15 + 1 wraps to 0 with carry
        issue(3'd7, 4'd0);
        res_is("ones", 4'd15, 1'b0, 1'b0);
        consume("ones");
        issue(3'd3, 4'd1);
        res_is("wrap", 4'd0, 1'b1, 1'b1);
`ifdef ACCUM_OVF_CNT_EN
        chk("wrap_ovf_cnt", 32'(ovf_cnt), 32'd1);
`else
        chk("wrap_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
        consume("wrap");

        // ACC = 3; 3 - 10 = 9 borrow; then 2 - 9 = 9 borrow
        issue(3'd3, 4'd3);
        res_is("load3", 4'd3, 1'b0, 1'b0);
        consume("load3");
        issue(3'd2, 4'd10);
        res_is("asubb", 4'd9, 1'b1, 1'b0);
        consume("asubb");
        issue(3'd1, 4'd2);
        res_is("bsuba", 4'd9, 1'b1, 1'b0);
        consume("bsuba");

        // 9 ^ 6 = 15, then stall the consumer for 5 cycles with a command pending
        bus.res_ready = 1'b0;
        issue(3'd4, 4'd6);
        res_is("xor", 4'd15, 1'b0, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd6;
        bus.cmd_data  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_res_valid", 32'(bus.res_valid), 32'd1);
            chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            res_is("stall", 4'd15, 1'b0, 1'b0);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("b2b_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("b2b_res_valid_edge1", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        chk("b2b_res_valid_edge2", 32'(bus.res_valid), 32'd1);
        res_is("b2b_and", 4'd5, 1'b0, 1'b0);
        consume("b2b");

        // Reset pulsed while the command is executing
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd3;
        bus.cmd_data  = 4'd1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        clr = 1'b0;
        #1;
        chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("midrst_res_data",  32'(bus.res_data),  32'd0);
        chk("midrst_res_carry", 32'(bus.res_carry), 32'd0);
        chk("midrst_res_zero",  32'(bus.res_zero),  32'd0);
        chk("midrst_ovf_cnt",   32'(ovf_cnt),       32'd0);
        #2 clr = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_result", 32'(bus.res_valid), 32'd0);
            @(posedge clk); #1;
        end

        // 0 & 15 = 0 after reset
        issue(3'd6, 4'd15);
        res_is("and_post_rst", 4'd0, 1'b0, 1'b1);
        consume("and_post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
